// File: rtl/decode_stage.sv
// MIPS-32 decode pipeline stage: field split, format classification,
// immediate extension, destination/read-usage decode, load-use bubble insertion.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [25:0]      jaddr,
  output logic [XLEN-1:0]  imm_ext,
  output logic [1:0]       fmt,
  output logic [4:0]       dest,
  output logic             reg_write,
  output logic             is_load,
  output logic [CNT_W-1:0] bubble_count
);

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  logic [5:0]      d_op;
  logic [4:0]      d_rs;
  logic [4:0]      d_rt;
  logic [4:0]      d_rd;
  logic [1:0]      d_fmt;
  logic [XLEN-1:0] d_imm;
  logic [4:0]      d_dest;
  logic            d_store;
  logic            d_branch;
  logic            d_load;
  logic            d_reads_rs;
  logic            d_reads_rt;
  logic            hazard;
  logic            accept;
  logic            bump;

  // Decode the incoming instruction word.
  always_comb begin
    d_op       = in_instr[31:26];
    d_rs       = in_instr[25:21];
    d_rt       = in_instr[20:16];
    d_rd       = in_instr[15:11];
    d_fmt      = FMT_I;
    d_imm      = XLEN'($signed(in_instr[15:0]));
    d_dest     = 5'd0;
    d_store    = d_op inside {6'h28, 6'h29, 6'h2B};
    d_branch   = (d_op == 6'h01) || (d_op inside {[6'h04:6'h07]});
    d_load     = d_op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    d_reads_rs = 1'b0;
    d_reads_rt = 1'b0;

    if (d_op == OP_RTYPE) begin
      d_fmt = FMT_R;
    end else if ((d_op == OP_J) || (d_op == OP_JAL)) begin
      d_fmt = FMT_J;
    end

    case (d_op)
      OP_ANDI, OP_ORI, OP_XORI: d_imm = XLEN'(in_instr[15:0]);
      OP_LUI:                   d_imm = XLEN'($signed({in_instr[15:0], 16'h0000}));
      OP_J, OP_JAL:             d_imm = '0;
      default:                  d_imm = XLEN'($signed(in_instr[15:0]));
    endcase

    case (d_fmt)
      FMT_R: begin
        d_dest     = d_rd;
        d_reads_rs = 1'b1;
        d_reads_rt = 1'b1;
      end
      FMT_J: begin
        d_dest = (d_op == OP_JAL) ? 5'd31 : 5'd0;
      end
      default: begin
        d_dest     = (d_store || d_branch) ? 5'd0 : d_rt;
        d_reads_rs = 1'b1;
        d_reads_rt = d_store || (d_op == OP_BEQ) || (d_op == OP_BNE);
      end
    endcase
  end

  // Load-use hazard against the held instruction, and the handshake it gates.
  always_comb begin
    hazard = out_valid && is_load && reg_write &&
             ((d_reads_rs && (d_rs == dest)) || (d_reads_rt && (d_rt == dest)));
    in_ready = !flush && !hazard && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    bump     = in_valid && hazard && out_ready && !flush;
  end

  // Output register: load on accept, clear valid on drain or flush, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      opcode    <= '0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      shamt     <= '0;
      funct     <= '0;
      jaddr     <= '0;
      imm_ext   <= '0;
      fmt       <= FMT_R;
      dest      <= '0;
      reg_write <= 1'b0;
      is_load   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      opcode    <= d_op;
      rs        <= d_rs;
      rt        <= d_rt;
      rd        <= d_rd;
      shamt     <= in_instr[10:6];
      funct     <= in_instr[5:0];
      jaddr     <= in_instr[25:0];
      imm_ext   <= d_imm;
      fmt       <= d_fmt;
      dest      <= d_dest;
      reg_write <= (d_dest != 5'd0);
      is_load   <= d_load;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (bump && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a behavioural model of the stage.
module tb_decode_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [5:0]       opcode;
  logic [4:0]       rs, rt, rd, shamt;
  logic [5:0]       funct;
  logic [25:0]      jaddr;
  logic [XLEN-1:0]  imm_ext;
  logic [1:0]       fmt;
  logic [4:0]       dest;
  logic             reg_write;
  logic             is_load;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .jaddr(jaddr), .imm_ext(imm_ext), .fmt(fmt), .dest(dest),
    .reg_write(reg_write), .is_load(is_load), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [25:0] ja;
    logic [31:0] imm;
    logic [1:0]  fmt;
    logic [4:0]  dest;
    logic        rw;
    logic        ld;
    logic        rrs;
    logic        rrt;
  } exp_t;

  // Reference decode straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    int   op;
    int   v;
    bit   is_store;
    bit   is_branch;
    op        = int'(w[31:26]);
    v         = int'(w[15:0]);
    is_store  = (op == 'h28) || (op == 'h29) || (op == 'h2B);
    is_branch = (op == 'h01) || (op >= 'h04 && op <= 'h07);
    e     = '0;
    e.op  = w[31:26];
    e.rs  = w[25:21];
    e.rt  = w[20:16];
    e.rd  = w[15:11];
    e.sh  = w[10:6];
    e.fn  = w[5:0];
    e.ja  = w[25:0];
    if (op == 0) e.fmt = 2'd0;
    else if (op == 2 || op == 3) e.fmt = 2'd2;
    else e.fmt = 2'd1;
    if (e.fmt == 2'd2) e.imm = 32'd0;
    else if (op >= 'h0C && op <= 'h0E) e.imm = 32'(v);
    else if (op == 'h0F) e.imm = 32'(v * 65536);
    else e.imm = 32'((v >= 32768) ? v - 65536 : v);
    if (e.fmt == 2'd0) e.dest = e.rd;
    else if (op == 3) e.dest = 5'd31;
    else if (op == 2 || is_store || is_branch) e.dest = 5'd0;
    else e.dest = e.rt;
    e.rw  = (e.dest != 5'd0);
    e.ld  = (op == 'h20) || (op == 'h21) || (op == 'h23) || (op == 'h24) || (op == 'h25);
    e.rrs = (e.fmt != 2'd2);
    e.rrt = (e.fmt == 2'd0) || is_store || op == 'h04 || op == 'h05;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (bubble_count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bubble_count); end
    checks++; if (imm_ext !== '0 || out_pc !== '0 || dest !== '0) begin failures++; $display("FAIL reset_data imm=%h pc=%h dest=%0d exp=0", imm_ext, out_pc, dest); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    exp_cnt = 0;
  endtask

  task automatic test_r_format();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00221820; in_pc = 32'h100;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL r_valid got=%b exp=1", out_valid); end
    checks++; if ({fmt, rs, rt, rd, shamt, funct} !== {2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20})
      begin failures++; $display("FAIL r_fields got fmt=%0d rs=%0d rt=%0d rd=%0d sh=%0d fn=%h exp 0/1/2/3/0/20", fmt, rs, rt, rd, shamt, funct); end
    checks++; if (dest !== 5'd3 || reg_write !== 1'b1 || is_load !== 1'b0)
      begin failures++; $display("FAIL r_dest got dest=%0d rw=%b ld=%b exp 3/1/0", dest, reg_write, is_load); end
    checks++; if (out_pc !== 32'h100) begin failures++; $display("FAIL r_pc got=%h exp=100", out_pc); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL r_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_immediates();
    logic [31:0] ins [7];
    logic [31:0] imm [7];
    ins = '{32'h2005FFFC, 32'h3405FFFC, 32'h3C051234, 32'h3C058000, 32'h30058001, 32'h38058001, 32'h28058001};
    imm = '{32'hFFFFFFFC, 32'h0000FFFC, 32'h12340000, 32'h80000000, 32'h00008001, 32'h00008001, 32'hFFFF8001};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_instr = ins[i];
      step();
      checks++; if (out_valid !== 1'b1 || imm_ext !== imm[i] || fmt !== 2'd1)
        begin failures++; $display("FAIL imm_%0d got v=%b imm=%h fmt=%0d exp v=1 imm=%h fmt=1", i, out_valid, imm_ext, fmt, imm[i]); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_jump_store_branch();
    logic [31:0] ins  [5];
    logic [1:0]  efmt [5];
    logic [4:0]  edst [5];
    logic [31:0] eimm [5];
    ins  = '{32'h0C100000, 32'h08100000, 32'hAC220004, 32'h1022FFFF, 32'h20000005};
    efmt = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
    edst = '{5'd31, 5'd0, 5'd0, 5'd0, 5'd0};
    eimm = '{32'h0, 32'h0, 32'h4, 32'hFFFFFFFF, 32'h5};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = ins[i];
      step();
      checks++; if (fmt !== efmt[i] || dest !== edst[i] || reg_write !== (edst[i] != 5'd0) || imm_ext !== eimm[i])
        begin failures++; $display("FAIL jsb_%0d got fmt=%0d dest=%0d rw=%b imm=%h exp fmt=%0d dest=%0d imm=%h", i, fmt, dest, reg_write, imm_ext, efmt[i], edst[i], eimm[i]); end
    end
    checks++; if (jaddr !== 26'h0000005) begin failures++; $display("FAIL jsb_jaddr_tail got=%h exp=0000005", jaddr); end
    in_valid = 1'b1; in_instr = 32'h0C100000;
    step();
    checks++; if (jaddr !== 26'h0100000) begin failures++; $display("FAIL jal_jaddr got=%h exp=0100000", jaddr); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_load_use();
    logic [31:0] ld  [8];
    logic [31:0] sec [8];
    bit          hz  [8];
    ld  = '{32'h8C240000, 32'h8C240000, 32'h8C240000, 32'h8C240000, 32'h8C240000, 32'h8C240000, 32'h8C200000, 32'h90240000};
    sec = '{32'h00823020, 32'h00E23020, 32'h00443020, 32'hAC240000, 32'h34A40001, 32'h10240003, 32'h00023020, 32'h00823020};
    hz  = '{1, 0, 1, 1, 0, 1, 0, 1};
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = ld[i]; in_pc = 32'h400;
      step();
      in_instr = sec[i]; in_pc = 32'h404;
      #1;
      checks++; if (in_ready !== !hz[i]) begin failures++; $display("FAIL lu_ready_%0d got=%b exp=%b", i, in_ready, !hz[i]); end
      if (hz[i]) begin
        if (exp_cnt < CMAX) exp_cnt++;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_gap_%0d got=%b exp=0", i, out_valid); end
      end
      step();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h404)
        begin failures++; $display("FAIL lu_second_%0d got v=%b pc=%h exp v=1 pc=404", i, out_valid, out_pc); end
      checks++; if (bubble_count !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL lu_count_%0d got=%0d exp=%0d", i, bubble_count, exp_cnt); end
      in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_instr = 32'h20050007; in_pc = 32'h200;
    step();
    in_instr = 32'h20060008; in_pc = 32'h204;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || imm_ext !== 32'h7 || dest !== 5'd5)
        begin failures++; $display("FAIL bp_hold_%0d got rdy=%b v=%b pc=%h imm=%h dest=%0d", i, in_ready, out_valid, out_pc, imm_ext, dest); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || imm_ext !== 32'h8)
      begin failures++; $display("FAIL bp_next got v=%b pc=%h imm=%h exp 1/204/8", out_valid, out_pc, imm_ext); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h20050001; in_pc = 32'h300;
    step();
    in_instr = 32'h20050002; in_pc = 32'h304; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    flush = 1'b0; in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_not_taken got=%b exp=0", out_valid); end
    in_valid = 1'b1; in_instr = 32'h8C240000;
    step();
    in_instr = 32'h00823020; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || bubble_count !== CNT_W'(exp_cnt))
      begin failures++; $display("FAIL flush_hazard got v=%b cnt=%0d exp v=0 cnt=%0d", out_valid, bubble_count, exp_cnt); end
    step();
  endtask

  task automatic test_bubble_saturation();
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_instr = 32'h8C240000;
      step();
      in_instr = 32'h00823020;
      step();
      if (exp_cnt < CMAX) exp_cnt++;
      step();
      in_valid = 1'b0;
      step();
      checks++; if (bubble_count !== CNT_W'(exp_cnt)) begin failures++; $display("FAIL sat_%0d got=%0d exp=%0d", i, bubble_count, exp_cnt); end
    end
  endtask

  task automatic test_random();
    logic [5:0] pool [16];
    exp_t       m;
    exp_t       d;
    logic [31:0] m_pc;
    bit          m_valid;
    int          m_cnt;
    bit          haz;
    bit          e_ready;
    pool = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h01,
             6'h08, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h24, 6'h2B, 6'h3F};
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    step();
    rst = 1'b0;
    m = '0; m_pc = '0; m_valid = 1'b0; m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid); end
      checks++; if (bubble_count !== CNT_W'(m_cnt)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, bubble_count, m_cnt); end
      if (m_valid) begin
        checks++;
        if ({opcode, rs, rt, rd, shamt, funct, jaddr, imm_ext, fmt, dest, reg_write, is_load, out_pc} !==
            {m.op, m.rs, m.rt, m.rd, m.sh, m.fn, m.ja, m.imm, m.fmt, m.dest, m.rw, m.ld, m_pc}) begin
          failures++;
          $display("FAIL rand_data cyc=%0d got op=%h imm=%h fmt=%0d dest=%0d rw=%b ld=%b pc=%h exp op=%h imm=%h fmt=%0d dest=%0d rw=%b ld=%b pc=%h",
                   cyc, opcode, imm_ext, fmt, dest, reg_write, is_load, out_pc, m.op, m.imm, m.fmt, m.dest, m.rw, m.ld, m_pc);
        end
      end
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 11) == 0);
      in_instr  = {pool[$urandom_range(0, 15)], 2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7)),
                   2'b00, 3'($urandom_range(0, 7)), 11'($urandom)};
      in_pc     = $urandom;
      #1;
      d = ref_decode(in_instr);
      haz = m_valid && m.ld && m.rw && ((d.rrs && d.rs == m.dest) || (d.rrt && d.rt == m.dest));
      e_ready = !flush && !haz && (!m_valid || out_ready);
      if (!rst) begin
        checks++; if (in_ready !== e_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_ready); end
      end
      if (rst) begin
        m = '0; m_pc = '0; m_valid = 1'b0; m_cnt = 0;
      end else begin
        if (in_valid && haz && out_ready && !flush && m_cnt < int'(CMAX)) m_cnt++;
        if (in_valid && e_ready) begin
          m = d; m_pc = in_pc; m_valid = 1'b1;
        end else if (flush || (m_valid && out_ready)) begin
          m_valid = 1'b0;
        end
      end
      step();
    end
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    exp_cnt = m_cnt;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_instr = 32'h8C240000; in_pc = 32'h500;
    step();
    in_instr = 32'h00823020;
    step();
    out_ready = 1'b0; in_instr = 32'h3C051234; in_pc = 32'h504;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    exp_cnt = 0;
    checks++; if (out_valid !== 1'b0 || bubble_count !== '0)
      begin failures++; $display("FAIL midrst_state got v=%b cnt=%0d exp 0/0", out_valid, bubble_count); end
    checks++; if (out_pc !== '0 || imm_ext !== '0 || opcode !== '0 || reg_write !== 1'b0)
      begin failures++; $display("FAIL midrst_data got pc=%h imm=%h op=%h rw=%b exp 0", out_pc, imm_ext, opcode, reg_write); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_r_format();
    test_immediates();
    test_jump_store_branch();
    test_load_use();
    test_backpressure();
    test_flush();
    test_bubble_saturation();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
